// File: rtl/score_recorder_if.sv
// Write port between the score recorder and the cellular-RAM memory controller.
//
//   req  : write request, high while a command word is pending
//   addr : word address of the pending write
//   data : 16-bit command word
//   ack  : controller has accepted the pending write this cycle
//
// master = recorder side, slave = memory controller side.
interface score_recorder_if #(
    parameter int ADDR_W = 23
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic              ack;

    modport master (output req, addr, data, input ack);
    modport slave  (input req, addr, data, output ack);
endinterface

// File: rtl/score_recorder.sv
// Song recorder: encodes note / BPM / end-of-song events into 16-bit command
// words, buffers them in a small FIFO and writes them to consecutive RAM word
// addresses through a request/acknowledge write port.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   rec_start           : strobe, begin a new recording at BASE_ADDR
//   note_stb, tone,
//   mode, note          : strobe + fields of a note event
//   bpm_stb, bpm        : strobe + new tempo
//   end_stb             : strobe, close the recording
//   wr                  : write port to the memory controller (master side)
//   recording           : high while accepting events or draining
//   done                : recording closed and every word written
//   ovf                 : sticky, an event was dropped or address space ran out
//   word_count          : words written in this recording
module score_recorder #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_W-1:0] LAST_ADDR  = '1,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_start,
    input  logic              note_stb,
    input  logic [5:0]        tone,
    input  logic [1:0]        mode,
    input  logic [3:0]        note,
    input  logic              bpm_stb,
    input  logic [7:0]        bpm,
    input  logic              end_stb,
    score_recorder_if.master  wr,
    output logic              recording,
    output logic              done,
    output logic              ovf,
    output logic [ADDR_W-1:0] word_count
);
    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]  ONE_CNT  = (PTR_W+1)'(1);
    localparam logic [15:0]     END_WORD = 16'hC000;

    typedef enum logic [1:0] {S_IDLE, S_REC, S_DRAIN, S_FIN} state_t;

    state_t            state_reg, state_next;
    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg, rd_after;
    logic [PTR_W:0]    count_reg, count_next, count_after_pop;
    logic [ADDR_W-1:0] slot_addr_reg;      // address the next enqueued word will land on
    logic              end_pend_reg, end_pend_next;
    logic              ovf_reg, ovf_next, done_reg, done_next;
    logic              wr_req_reg;
    logic [ADDR_W-1:0] wr_addr_reg, word_count_reg;
    logic [15:0]       wr_data_reg, head_next;
    logic              recording_reg;
    logic              enq, pop, full, start, exhaust, want_end;
    logic [15:0]       enq_word, note_word, bpm_word;

    assign note_word = {(mode == 2'b11) ? 2'b00 : mode, tone, 4'b0000, note};
    assign bpm_word  = {2'b11, 6'b000000, (bpm == 8'd0) ? 8'd1 : bpm};

    assign full     = (count_reg == FULL_CNT);
    assign pop      = wr_req_reg && wr.ack;
    assign exhaust  = (slot_addr_reg == LAST_ADDR);
    assign want_end = end_stb || end_pend_reg;

    always_comb begin
        state_next    = state_reg;
        enq           = 1'b0;
        enq_word      = END_WORD;
        end_pend_next = end_pend_reg;
        ovf_next      = ovf_reg;
        done_next     = done_reg;
        start         = 1'b0;
        case (state_reg)
            S_IDLE, S_FIN: begin
                if (rec_start) begin
                    start         = 1'b1;
                    state_next    = S_REC;
                    ovf_next      = 1'b0;
                    done_next     = 1'b0;
                    end_pend_next = 1'b0;
                end
            end
            S_REC: begin
                if (want_end || exhaust) begin
                    // Reaching the reserved last slot without an end request
                    // means the recording was cut short.
                    if (note_stb || bpm_stb || !want_end)
                        ovf_next = 1'b1;
                    if (!full) begin
                        enq           = 1'b1;
                        enq_word      = END_WORD;
                        end_pend_next = 1'b0;
                        state_next    = S_DRAIN;
                    end else begin
                        end_pend_next = 1'b1;
                    end
                end else if (bpm_stb) begin
                    if (note_stb || full)
                        ovf_next = 1'b1;
                    if (!full) begin
                        enq      = 1'b1;
                        enq_word = bpm_word;
                    end
                end else if (note_stb) begin
                    if (full) begin
                        ovf_next = 1'b1;
                    end else begin
                        enq      = 1'b1;
                        enq_word = note_word;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && count_reg == ONE_CNT) begin
                    state_next = S_FIN;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Occupancy and the word that will sit at the head after this edge.
    always_comb begin
        count_next = count_reg;
        case ({enq, pop})
            2'b10:   count_next = count_reg + ONE_CNT;
            2'b01:   count_next = count_reg - ONE_CNT;
            default: count_next = count_reg;
        endcase
        rd_after        = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        count_after_pop = count_reg - {{PTR_W{1'b0}}, pop};
        head_next       = (count_after_pop == '0) ? enq_word : fifo_mem[rd_after];
    end

    always_ff @(posedge clk) begin
        if (enq)
            fifo_mem[wr_ptr_reg] <= enq_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            slot_addr_reg  <= BASE_ADDR;
            end_pend_reg   <= 1'b0;
            ovf_reg        <= 1'b0;
            done_reg       <= 1'b0;
            wr_req_reg     <= 1'b0;
            wr_addr_reg    <= BASE_ADDR;
            wr_data_reg    <= '0;
            word_count_reg <= '0;
            recording_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            end_pend_reg  <= end_pend_next;
            ovf_reg       <= ovf_next;
            done_reg      <= done_next;
            recording_reg <= (state_next == S_REC) || (state_next == S_DRAIN);
            if (start) begin
                wr_ptr_reg     <= '0;
                rd_ptr_reg     <= '0;
                count_reg      <= '0;
                slot_addr_reg  <= BASE_ADDR;
                wr_addr_reg    <= BASE_ADDR;
                word_count_reg <= '0;
                wr_req_reg     <= 1'b0;
            end else begin
                count_reg  <= count_next;
                wr_req_reg <= (count_next != '0);
                if (pop) begin
                    rd_ptr_reg     <= rd_ptr_reg + 1'b1;
                    wr_addr_reg    <= wr_addr_reg + 1'b1;
                    word_count_reg <= word_count_reg + 1'b1;
                end
                if (enq) begin
                    wr_ptr_reg    <= wr_ptr_reg + 1'b1;
                    slot_addr_reg <= slot_addr_reg + 1'b1;
                end
                if (count_next != '0)
                    wr_data_reg <= head_next;
            end
        end
    end

    assign wr.req     = wr_req_reg;
    assign wr.addr    = wr_addr_reg;
    assign wr.data    = wr_data_reg;
    assign recording  = recording_reg;
    assign done       = done_reg;
    assign ovf        = ovf_reg;
    assign word_count = word_count_reg;
endmodule

// File: tb/tb_score_recorder.sv
// Bench for score_recorder: directed scenarios followed by randomized
// recordings. A queue-based reference model predicts every RAM write and the
// status outputs; a separate monitor compares the DUT against it each cycle.
module tb_score_recorder;
    localparam int            AW    = 23;
    localparam logic [AW-1:0] BASE  = '0;
    localparam logic [AW-1:0] LAST  = 23'd11;
    localparam int            DEPTH = 4;

    localparam int M_IDLE = 0, M_REC = 1, M_DRAIN = 2, M_FIN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, rec_start = 1'b0, note_stb = 1'b0, bpm_stb = 1'b0, end_stb = 1'b0;
    logic [5:0]    tone = '0;
    logic [1:0]    mode = '0;
    logic [3:0]    note = '0;
    logic [7:0]    bpm  = '0;
    logic          recording, done, ovf;
    logic [AW-1:0] word_count;

    score_recorder_if #(.ADDR_W(AW)) wr_if ();

    score_recorder #(
        .ADDR_W(AW), .BASE_ADDR(BASE), .LAST_ADDR(LAST), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rec_start(rec_start),
        .note_stb(note_stb), .tone(tone), .mode(mode), .note(note),
        .bpm_stb(bpm_stb), .bpm(bpm), .end_stb(end_stb),
        .wr(wr_if), .recording(recording), .done(done), .ovf(ovf),
        .word_count(word_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int             m_state = M_IDLE;
    logic [15:0]    mq[$];          // words buffered but not yet accepted
    logic [AW+15:0] exp_q[$];       // {addr, data} of every expected write
    int             m_wc = 0, m_enq = 0;
    bit             m_ovf = 0, m_done = 0, m_pend = 0, m_just_reset = 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc_note(logic [1:0] md, logic [5:0] t, logic [3:0] n);
        int m;
        m = (md == 2'b11) ? 0 : int'(md);
        return 16'(m * 16384 + int'(t) * 256 + int'(n));
    endfunction

    function automatic logic [15:0] enc_bpm(logic [7:0] b);
        int v;
        v = (b == 8'd0) ? 1 : int'(b);
        return 16'(49152 + v);
    endfunction

    task automatic push_word(logic [15:0] w);
        mq.push_back(w);
        exp_q.push_back({AW'(int'(BASE) + m_enq), w});
        m_enq++;
    endtask

    // One clock edge of the reference behaviour, using the inputs just sampled.
    task automatic model_step();
        bit full, pop, want_end, exhaust;
        if (rst) begin
            m_state = M_IDLE; mq.delete(); exp_q.delete();
            m_wc = 0; m_enq = 0; m_ovf = 0; m_done = 0; m_pend = 0; m_just_reset = 1;
            return;
        end
        m_just_reset = 0;
        full = (mq.size() == DEPTH);
        pop  = (mq.size() > 0) && wr_if.ack;
        if (pop) begin
            void'(mq.pop_front());
            m_wc++;
        end
        case (m_state)
            M_IDLE, M_FIN: begin
                if (rec_start) begin
                    m_state = M_REC; m_wc = 0; m_enq = 0;
                    m_ovf = 0; m_done = 0; m_pend = 0; mq.delete();
                end
            end
            M_REC: begin
                want_end = end_stb || m_pend;
                exhaust  = (int'(BASE) + m_enq) == int'(LAST);
                if (want_end || exhaust) begin
                    if (note_stb || bpm_stb || !want_end) m_ovf = 1;
                    if (!full) begin
                        push_word(16'hC000);
                        m_pend = 0;
                        m_state = M_DRAIN;
                    end else begin
                        m_pend = 1;
                    end
                end else if (bpm_stb) begin
                    if (note_stb || full) m_ovf = 1;
                    if (!full) push_word(enc_bpm(bpm));
                end else if (note_stb) begin
                    if (full) m_ovf = 1;
                    else push_word(enc_note(mode, tone, note));
                end
            end
            default: begin
                if (pop && mq.size() == 0) begin
                    m_state = M_FIN;
                    m_done = 1;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        rec_start = 1'b0; note_stb = 1'b0; bpm_stb = 1'b0; end_stb = 1'b0;
    endtask

    task automatic rand_note_fields();
        tone = 6'($urandom_range(0, 63));
        mode = 2'($urandom_range(0, 3));
        note = 4'($urandom_range(0, 15));
    endtask

    task automatic rand_events(int p_note, int p_bpm, int p_end);
        rand_note_fields();
        bpm      = 8'($urandom_range(0, 255));
        note_stb = ($urandom_range(0, 99) < p_note);
        bpm_stb  = ($urandom_range(0, 99) < p_bpm);
        end_stb  = ($urandom_range(0, 99) < p_end);
    endtask

    task automatic wait_done(int max, bit rnd);
        for (int i = 0; i < max; i++) begin
            if (done) break;
            if (rnd) begin
                wr_if.ack = ($urandom_range(0, 99) < 60);
                rand_events(30, 10, 5);
            end
            tick();
        end
        chk("done_timeout", done, 1);
    endtask

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        chk("wr_req", wr_if.req, mq.size() != 0);
        chk("wr_addr", wr_if.addr, AW'(int'(BASE) + m_wc));
        chk("word_count", word_count, AW'(m_wc));
        chk("recording", recording, (m_state == M_REC) || (m_state == M_DRAIN));
        chk("done", done, m_done);
        chk("ovf", ovf, m_ovf);
        if (m_just_reset)
            chk("wr_data_rst", wr_if.data, 0);
        if (wr_if.req) begin
            chk("exp_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                chk("wr_addr_head", wr_if.addr, exp_q[0][AW+15:16]);
                chk("wr_data", wr_if.data, exp_q[0][15:0]);
                if (wr_if.ack && !rst) begin
                    $display("write addr=%0d data=%04h", wr_if.addr, wr_if.data);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_if.ack = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Note encoding then end, ACK tied high
        wr_if.ack = 1'b1;
        rec_start = 1'b1; tick();
        tone = 6'h15; mode = 2'b01; note = 4'h4; note_stb = 1'b1; tick();
        tick();
        end_stb = 1'b1; tick();
        wait_done(20, 0);

        // BPM encodings and MODE=11 coercion
        rec_start = 1'b1; tick();
        bpm = 8'd80; bpm_stb = 1'b1; tick();
        bpm = 8'd0;  bpm_stb = 1'b1; tick();
        mode = 2'b11; tone = 6'd3; note = 4'd2; note_stb = 1'b1; tick();
        end_stb = 1'b1; tick();
        wait_done(20, 0);

        // Backpressure: five notes into a four-deep buffer
        wr_if.ack = 1'b0;
        rec_start = 1'b1; tick();
        repeat (5) begin rand_note_fields(); note_stb = 1'b1; tick(); end
        repeat (3) tick();
        wr_if.ack = 1'b1;
        end_stb = 1'b1; tick();
        wait_done(30, 0);

        // Simultaneous strobes, then END while full and ACK low
        rec_start = 1'b1; tick();
        wr_if.ack = 1'b0;
        note_stb = 1'b1; bpm_stb = 1'b1; bpm = 8'd120; rand_note_fields(); tick();
        repeat (3) begin rand_note_fields(); note_stb = 1'b1; tick(); end
        end_stb = 1'b1; tick();
        repeat (4) tick();
        wr_if.ack = 1'b1;
        wait_done(30, 0);

        // Address exhaustion: more notes than slots before LAST
        rec_start = 1'b1; tick();
        repeat (15) begin rand_note_fields(); note_stb = 1'b1; tick(); end
        wait_done(30, 0);
        repeat (5) begin note_stb = 1'b1; bpm_stb = 1'b1; end_stb = 1'b1; tick(); end

        // Reset with three words queued
        rec_start = 1'b1; tick();
        wr_if.ack = 1'b0;
        repeat (3) begin rand_note_fields(); note_stb = 1'b1; tick(); end
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        rec_start = 1'b1; tick();
        wr_if.ack = 1'b1;
        rand_note_fields(); note_stb = 1'b1; tick();
        end_stb = 1'b1; tick();
        wait_done(20, 0);

        // Randomized recordings
        for (int r = 0; r < 40; r++) begin
            rec_start = 1'b1; tick();
            for (int c = 0; c < int'($urandom_range(0, 25)); c++) begin
                wr_if.ack = ($urandom_range(0, 99) < 60);
                rand_events(40, 15, 3);
                rec_start = ($urandom_range(0, 99) < 3);
                tick();
            end
            end_stb = 1'b1; tick();
            if (m_state != M_IDLE)
                wait_done(300, 1);
        end

        wr_if.ack = 1'b1;
        repeat (3) tick();
        chk("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/score_recorder.md
# score_recorder

Encoder/writer for the song command-word format that the playback path reads from cellular RAM. Accepts live note events, BPM changes and an end-of-song strobe from the front panel/motion input, encodes each into one 16-bit command word, buffers up to FIFO_DEPTH words, and writes them to consecutive RAM word addresses through a request/acknowledge write port on the memory controller. A recording always ends with an end-of-song word so the player can detect the end of the stream.

## Interface
- ADDR_W, 23, word-address width (matches ADDR[23:1])
- BASE_ADDR, 0, first word address of a recording
- LAST_ADDR, 2^23-1, highest usable word address
- FIFO_DEPTH, 4, pending-word buffer depth (power of two, ≥2)
- CLK  in  1  100 MHz system clock
- RST  in  1  synchronous, active-high reset
- REC_START  in  1  strobe: begin a new recording at BASE_ADDR
- NOTE_STB  in  1  strobe: encode a note from TONE/MODE/NOTE
- TONE  in  6  tone index
- MODE  in  2  00 normal, 01 staccato, 10 slurred
- NOTE  in  4  duration code
- BPM_STB  in  1  strobe: encode a BPM change
- BPM  in  8  new tempo, beats per minute
- END_STB  in  1  strobe: close the recording
- WR_REQ  out  1  write request to memory controller
- WR_ADDR  out  ADDR_W  word address
- WR_DATA  out  16  command word
- WR_ACK  in  1  controller has accepted the write
- RECORDING  out  1  high in REC and DRAIN
- DONE  out  1  recording closed and fully written
- OVF  out  1  sticky: event dropped or address space exhausted
- WORD_COUNT  out  ADDR_W  words written in this recording

## Operation
- Encodings:
  - note: {MODE, TONE, 4'b0000, NOTE}. MODE=11 is coerced to 00.
  - BPM: {2'b11, 6'b0, BPM}. BPM=0 is replaced by 1.
  - end: 16'hC000, which is a BPM command carrying 0.
- States:
  - IDLE: reached after reset. All strobes except REC_START are ignored.
  - REC: accepts events.
  - DRAIN: the end word is queued and no further events are accepted. Leaves when the FIFO is empty and the last WR_ACK is seen.
  - FIN: DONE=1. Only REC_START is honoured.
- REC_START in IDLE or FIN:
  - next cycle: REC
  - address=BASE_ADDR, WORD_COUNT=0, OVF=0, DONE=0, FIFO flushed.
  - Ignored in REC and DRAIN.
- One word is enqueued per cycle, with priority END > BPM > NOTE. Lower-priority strobes in the same cycle are dropped and set OVF.
- A strobe that arrives while the FIFO is full is dropped and sets OVF.
  - Exception: END_STB with a full FIFO is held pending and enqueued on the first free slot. It is never lost.
  - Entry to DRAIN occurs when the end word is actually enqueued.
- Address exhaustion:
  - The slot at LAST_ADDR is reserved for the end word.
  - When BASE_ADDR + (words enqueued) reaches LAST_ADDR, the block auto-enqueues the end word, sets OVF and enters DRAIN.
- Write port:
  - WR_REQ=1 whenever the FIFO is non-empty. WR_DATA is the FIFO head.
  - WR_ADDR is BASE_ADDR+WORD_COUNT.
  - WR_ADDR and WR_DATA are held stable while WR_REQ=1 and WR_ACK=0.
  - On the cycle WR_ACK=1 with WR_REQ=1: pop the head, WORD_COUNT+1, address+1.
  - WR_ACK without WR_REQ is ignored.
- Enqueue and pop in the same cycle are both performed, with FIFO occupancy unchanged. A strobe into a full FIFO on a pop cycle is dropped (full is judged before the pop).

## Timing
- All outputs are registered.
- Reset values: WR_REQ=0, WR_ADDR=BASE_ADDR, WR_DATA=0, RECORDING=0, DONE=0, OVF=0, WORD_COUNT=0, state IDLE.
- RST mid-write drops WR_REQ at the next edge. The pending word is discarded and the controller must abandon the access.
- Strobe sampled at edge N with the FIFO empty: WR_REQ=1 and data valid after edge N.
- WR_ACK at edge M: the next word is presented after edge M. Back-to-back writes run at 1 word/cycle if ACK is held high.
- Final WR_ACK of the end word at edge K: DONE=1 and RECORDING=0 after edge K.
- Strobes are single-cycle pulses, already debounced and synchronised upstream.

## Test plan
- Note encoding: REC_START, then NOTE_STB with TONE=6'h15, MODE=01, NOTE=4'h4, WR_ACK tied high.
  - Expect one write: ADDR=0, DATA=16'h5504.
  - Then END_STB: ADDR=1, DATA=16'hC000, DONE=1, WORD_COUNT=2.
- BPM encoding: BPM_STB with BPM=8'd80 gives DATA=16'hC050.
  - BPM=0 gives 16'hC001.
  - NOTE_STB with MODE=11, TONE=3, NOTE=2 gives 16'h0302.
- Backpressure: WR_ACK held low, 5 NOTE_STBs.
  - FIFO holds 4 words; the 5th is dropped and OVF=1.
  - WR_ADDR/WR_DATA stay stable throughout.
  - Release ACK: addresses 0–3 are written in order.
- Simultaneous strobes: NOTE_STB+BPM_STB in the same cycle enqueues the BPM word only and sets OVF=1.
  - END_STB with the FIFO full and ACK low: after ACK resumes, the end word is still written last.
- Exhaustion: LAST_ADDR=BASE_ADDR+3, 5 NOTE_STBs.
  - Words are written at 0–2, then 16'hC000 at 3.
  - OVF=1 and DONE=1.
  - Further strobes are ignored until REC_START.
- Reset mid-operation: RST asserted while WR_REQ=1 with 3 words queued.
  - Next cycle: all outputs at reset values.
  - A subsequent REC_START restarts at ADDR 0 with WORD_COUNT=0.
